// File: rtl/rob_unit_if.sv
// Bundled decode / query / CDB / commit signals of the reorder buffer.
// The slave modport is the ROB side; master is the decoder/RS/LSB/IF side.
interface rob_unit_if #(parameter int ID_WIDTH = 4);
  logic                rdy_in;
  logic                dec2rob_en;
  logic [4:0]          dec_rd;
  logic                dec_isBranch, dec_isStore;
  logic [31:0]         dec_predPC;
  logic [ID_WIDTH-1:0] newTag;
  logic                isFull;
  logic [ID_WIDTH-1:0] query1_lab, query2_lab;
  logic                ready1, ready2;
  logic [31:0]         res1, res2;
  logic                rs_cdb_valid, lsb_cdb_valid;
  logic [ID_WIDTH-1:0] rs_cdb2lab, lsb_cdb2lab;
  logic [31:0]         rs_cdb2val, lsb_cdb2val;
  logic                commit_en;
  logic [4:0]          commit_rd;
  logic [31:0]         commit_val;
  logic [ID_WIDTH-1:0] commit_lab;
  logic                store_commit, flush;
  logic [31:0]         rob2if_newPC;

  modport slave (
    input  rdy_in, dec2rob_en, dec_rd, dec_isBranch, dec_isStore, dec_predPC,
           query1_lab, query2_lab, rs_cdb_valid, lsb_cdb_valid,
           rs_cdb2lab, lsb_cdb2lab, rs_cdb2val, lsb_cdb2val,
    output newTag, isFull, ready1, ready2, res1, res2, commit_en, commit_rd,
           commit_val, commit_lab, store_commit, flush, rob2if_newPC
  );

  modport master (
    output rdy_in, dec2rob_en, dec_rd, dec_isBranch, dec_isStore, dec_predPC,
           query1_lab, query2_lab, rs_cdb_valid, lsb_cdb_valid,
           rs_cdb2lab, lsb_cdb2lab, rs_cdb2val, lsb_cdb2val,
    input  newTag, isFull, ready1, ready2, res1, res2, commit_en, commit_rd,
           commit_val, commit_lab, store_commit, flush, rob2if_newPC
  );
endinterface

// File: rtl/rob_unit.sv
// Reorder buffer: circular queue of ROB_SIZE entries, in-order single commit, branch flush.
// Define ROB_BYPASS_EN to forward same-cycle CDB broadcasts to operand queries.

// One ROB slot; priority clear > alloc > retire > CDB capture.
module rob_entry (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr,
  input  logic        alloc,
  input  logic        retire,
  input  logic [4:0]  alloc_rd,
  input  logic        alloc_br,
  input  logic        alloc_st,
  input  logic [31:0] alloc_pc,
  input  logic        wr,
  input  logic [31:0] wr_val,
  output logic        busy,
  output logic        ready,
  output logic [31:0] value,
  output logic [4:0]  rd,
  output logic        is_branch,
  output logic        is_store,
  output logic [31:0] pred_pc
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      ready     <= 1'b0;
      value     <= '0;
      rd        <= '0;
      is_branch <= 1'b0;
      is_store  <= 1'b0;
      pred_pc   <= '0;
    end else if (rdy) begin
      if (clr) begin
        busy  <= 1'b0;
        ready <= 1'b0;
      end else if (alloc) begin
        busy      <= 1'b1;
        ready     <= 1'b0;
        value     <= '0;
        rd        <= alloc_rd;
        is_branch <= alloc_br;
        is_store  <= alloc_st;
        pred_pc   <= alloc_pc;
      end else if (retire) begin
        busy  <= 1'b0;
        ready <= 1'b0;
      end else if (busy && wr) begin
        ready <= 1'b1;
        value <= wr_val;
      end
    end
  end
endmodule

module rob_unit #(
  parameter int ROB_SIZE = 8,
  parameter int ID_WIDTH = 4
) (
  input logic       clk,
  input logic       rst_in,
  rob_unit_if.slave io
);
  localparam int IDX_W = $clog2(ROB_SIZE);
  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(ROB_SIZE);

  typedef struct packed {
    logic        ready;
    logic [31:0] val;
  } qry_rsp_t;

  logic [IDX_W-1:0] head, tail;
  logic [IDX_W:0]   count;

  logic [ROB_SIZE-1:0]       e_busy, e_ready, e_br, e_st;
  logic [ROB_SIZE-1:0][31:0] e_val, e_pc;
  logic [ROB_SIZE-1:0][4:0]  e_rd;

  logic is_full, do_commit, mispred, do_alloc;

  assign is_full   = (count == FULL_CNT);
  assign io.isFull = is_full;
  assign io.newTag = ID_WIDTH'(tail) + ID_WIDTH'(1);

  assign do_commit = io.rdy_in && e_busy[head] && e_ready[head];
  assign mispred   = do_commit && e_br[head] && (e_val[head] != e_pc[head]);
  // A mispredict clears every slot on this edge, so an allocation now would be lost anyway.
  assign do_alloc  = io.rdy_in && io.dec2rob_en && !is_full && !io.flush && !mispred;

  genvar i;
  generate
    for (i = 0; i < ROB_SIZE; i++) begin : g_ent
      logic rs_hit, lsb_hit;
      assign rs_hit  = io.rs_cdb_valid  && (io.rs_cdb2lab  == ID_WIDTH'(i + 1));
      assign lsb_hit = io.lsb_cdb_valid && (io.lsb_cdb2lab == ID_WIDTH'(i + 1));

      rob_entry u_ent (
        .clk      (clk),
        .rst      (rst_in),
        .rdy      (io.rdy_in),
        .clr      (mispred),
        .alloc    (do_alloc && (tail == IDX_W'(i))),
        .retire   (do_commit && (head == IDX_W'(i))),
        .alloc_rd (io.dec_rd),
        .alloc_br (io.dec_isBranch),
        .alloc_st (io.dec_isStore),
        .alloc_pc (io.dec_predPC),
        .wr       (rs_hit || lsb_hit),
        .wr_val   (rs_hit ? io.rs_cdb2val : io.lsb_cdb2val),
        .busy     (e_busy[i]),
        .ready    (e_ready[i]),
        .value    (e_val[i]),
        .rd       (e_rd[i]),
        .is_branch(e_br[i]),
        .is_store (e_st[i]),
        .pred_pc  (e_pc[i])
      );
    end
  endgenerate

  function automatic qry_rsp_t lookup(input logic [ID_WIDTH-1:0] lab,
                                      input logic [ROB_SIZE-1:0] rdy_v,
                                      input logic [ROB_SIZE-1:0][31:0] val_v);
    qry_rsp_t         r;
    logic [IDX_W-1:0] idx;
    idx     = IDX_W'(lab - ID_WIDTH'(1));
    r.ready = 1'b1;
    r.val   = '0;
    if (lab != '0) begin
      r.ready = rdy_v[idx];
      r.val   = val_v[idx];
    end
    return r;
  endfunction

  qry_rsp_t q1, q2;

  always_comb begin
    q1 = lookup(io.query1_lab, e_ready, e_val);
    q2 = lookup(io.query2_lab, e_ready, e_val);
`ifdef ROB_BYPASS_EN
    // rs applied last so it wins over lsb on an identical tag
    if (io.query1_lab != '0 && io.lsb_cdb_valid && io.lsb_cdb2lab == io.query1_lab) q1 = {1'b1, io.lsb_cdb2val};
    if (io.query1_lab != '0 && io.rs_cdb_valid  && io.rs_cdb2lab  == io.query1_lab) q1 = {1'b1, io.rs_cdb2val};
    if (io.query2_lab != '0 && io.lsb_cdb_valid && io.lsb_cdb2lab == io.query2_lab) q2 = {1'b1, io.lsb_cdb2val};
    if (io.query2_lab != '0 && io.rs_cdb_valid  && io.rs_cdb2lab  == io.query2_lab) q2 = {1'b1, io.rs_cdb2val};
`endif
  end

  assign io.ready1 = q1.ready;
  assign io.res1   = q1.val;
  assign io.ready2 = q2.ready;
  assign io.res2   = q2.val;

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      io.commit_en    <= 1'b0;
      io.store_commit <= 1'b0;
      io.flush        <= 1'b0;
      io.rob2if_newPC <= '0;
      io.commit_rd    <= '0;
      io.commit_val   <= '0;
      io.commit_lab   <= '0;
    end else if (!io.rdy_in) begin
      io.commit_en    <= 1'b0;
      io.store_commit <= 1'b0;
      io.flush        <= 1'b0;
    end else begin
      io.commit_en    <= 1'b0;
      io.store_commit <= 1'b0;
      io.flush        <= 1'b0;
      if (mispred) begin
        io.flush        <= 1'b1;
        io.rob2if_newPC <= e_val[head];
        head            <= '0;
        tail            <= '0;
        count           <= '0;
      end else begin
        if (do_commit) begin
          head          <= head + 1'b1;
          io.commit_lab <= ID_WIDTH'(head) + ID_WIDTH'(1);
          if (e_st[head]) begin
            io.store_commit <= 1'b1;
          end else if (!e_br[head]) begin
            io.commit_en  <= 1'b1;
            io.commit_rd  <= e_rd[head];
            io.commit_val <= e_val[head];
          end
        end
        if (do_alloc) tail <= tail + 1'b1;
        if (do_alloc && !do_commit)      count <= count + 1'b1;
        else if (!do_alloc && do_commit) count <= count - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rob_unit.sv
// Directed bench for rob_unit: reset, allocation, fill/wrap, commit kinds, flush, query, stall.
module tb_rob_unit;
  logic clk = 1'b0;
  logic rst_in = 1'b0;
  int   total = 0;
  int   bad = 0;

`ifdef ROB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  rob_unit_if #(.ID_WIDTH(4)) io ();

  rob_unit #(.ROB_SIZE(8), .ID_WIDTH(4)) dut (
    .clk   (clk),
    .rst_in(rst_in),
    .io    (io)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_cdb();
    io.rs_cdb_valid  = 1'b0;
    io.lsb_cdb_valid = 1'b0;
    io.rs_cdb2lab    = '0;
    io.lsb_cdb2lab   = '0;
    io.rs_cdb2val    = '0;
    io.lsb_cdb2val   = '0;
  endtask

  task automatic clear_in();
    io.rdy_in       = 1'b1;
    io.dec2rob_en   = 1'b0;
    io.dec_rd       = '0;
    io.dec_isBranch = 1'b0;
    io.dec_isStore  = 1'b0;
    io.dec_predPC   = '0;
    io.query1_lab   = '0;
    io.query2_lab   = '0;
    clear_cdb();
  endtask

  task automatic do_reset();
    clear_in();
    rst_in = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic alloc(input logic [4:0] rd, input logic br, input logic st, input logic [31:0] pc);
    io.dec2rob_en   = 1'b1;
    io.dec_rd       = rd;
    io.dec_isBranch = br;
    io.dec_isStore  = st;
    io.dec_predPC   = pc;
    tick();
    io.dec2rob_en   = 1'b0;
    io.dec_isBranch = 1'b0;
    io.dec_isStore  = 1'b0;
  endtask

  task automatic rs_put(input logic [3:0] lab, input logic [31:0] val);
    io.rs_cdb_valid = 1'b1;
    io.rs_cdb2lab   = lab;
    io.rs_cdb2val   = val;
  endtask

  task automatic lsb_put(input logic [3:0] lab, input logic [31:0] val);
    io.lsb_cdb_valid = 1'b1;
    io.lsb_cdb2lab   = lab;
    io.lsb_cdb2val   = val;
  endtask

  task automatic test_reset();
    clear_in();
    @(negedge clk);
    rst_in = 1'b1;
    #2;  // no clock edge yet: reset must act asynchronously
    total++; if (io.newTag !== 4'd1) begin bad++; $display("FAIL rst_newtag got=%0d want=1", io.newTag); end
    total++; if (io.isFull !== 1'b0) begin bad++; $display("FAIL rst_isfull got=%b want=0", io.isFull); end
    total++; if ({io.commit_en, io.store_commit, io.flush} !== 3'b000) begin bad++; $display("FAIL rst_pulses got=%b want=000", {io.commit_en, io.store_commit, io.flush}); end
    total++; if (io.rob2if_newPC !== 32'd0) begin bad++; $display("FAIL rst_newpc got=%h want=0", io.rob2if_newPC); end
    total++; if ({io.commit_rd, io.commit_val, io.commit_lab} !== 41'd0) begin bad++; $display("FAIL rst_commit_fields got=%h want=0", {io.commit_rd, io.commit_val, io.commit_lab}); end
    @(negedge clk);
    rst_in = 1'b0;
    @(negedge clk);
    // reset while a commit is pending
    alloc(5'd4, 1'b0, 1'b0, 32'd0);
    rs_put(4'd1, 32'd9);
    tick();
    clear_cdb();
    rst_in = 1'b1;
    tick();
    total++; if (io.commit_en !== 1'b0) begin bad++; $display("FAIL rst_midcommit got=%b want=0", io.commit_en); end
    rst_in = 1'b0;
    tick();
    total++; if (io.commit_en !== 1'b0) begin bad++; $display("FAIL rst_discard got=%b want=0", io.commit_en); end
    total++; if (io.newTag !== 4'd1) begin bad++; $display("FAIL rst_release_newtag got=%0d want=1", io.newTag); end
  endtask

  task automatic test_alloc();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      total++; if (io.newTag !== 4'(k + 1)) begin bad++; $display("FAIL alloc_tag%0d got=%0d want=%0d", k, io.newTag, k + 1); end
      alloc(5'(k + 1), 1'b0, 1'b0, 32'd0);
    end
    total++; if (io.newTag !== 4'd4) begin bad++; $display("FAIL alloc_newtag got=%0d want=4", io.newTag); end
    total++; if (io.isFull !== 1'b0) begin bad++; $display("FAIL alloc_isfull got=%b want=0", io.isFull); end
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      alloc(5'(k + 1), 1'b0, 1'b0, 32'd0);
      if (k == 6) begin
        total++; if (io.isFull !== 1'b0) begin bad++; $display("FAIL full_at7 got=%b want=0", io.isFull); end
      end
    end
    total++; if (io.isFull !== 1'b1) begin bad++; $display("FAIL full_at8 got=%b want=1", io.isFull); end
    total++; if (io.newTag !== 4'd1) begin bad++; $display("FAIL full_wrap_newtag got=%0d want=1", io.newTag); end
    io.dec2rob_en = 1'b1;
    io.dec_rd     = 5'd9;
    rs_put(4'd1, 32'h11);
    tick();
    clear_cdb();
    total++; if (io.newTag !== 4'd1 || io.isFull !== 1'b1) begin bad++; $display("FAIL full_blocked got=%0d/%b want=1/1", io.newTag, io.isFull); end
    tick();
    total++; if (io.commit_en !== 1'b1 || io.commit_val !== 32'h11 || io.commit_lab !== 4'd1) begin bad++; $display("FAIL full_commit got=%b/%h/%0d want=1/11/1", io.commit_en, io.commit_val, io.commit_lab); end
    total++; if (io.isFull !== 1'b0) begin bad++; $display("FAIL full_freed got=%b want=0", io.isFull); end
    tick();
    io.dec2rob_en = 1'b0;
    total++; if (io.isFull !== 1'b1 || io.newTag !== 4'd2) begin bad++; $display("FAIL full_refill got=%b/%0d want=1/2", io.isFull, io.newTag); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 7; k++) alloc(5'(k + 1), 1'b0, 1'b0, 32'd0);
    rs_put(4'd1, 32'h77);
    tick();
    clear_cdb();
    // commit and allocate on the same edge
    alloc(5'd20, 1'b0, 1'b0, 32'd0);
    total++; if (io.commit_en !== 1'b1 || io.commit_lab !== 4'd1) begin bad++; $display("FAIL b2b_commit got=%b/%0d want=1/1", io.commit_en, io.commit_lab); end
    total++; if (io.isFull !== 1'b0 || io.newTag !== 4'd1) begin bad++; $display("FAIL b2b_count got=%b/%0d want=0/1", io.isFull, io.newTag); end
    alloc(5'd21, 1'b0, 1'b0, 32'd0);
    total++; if (io.isFull !== 1'b1) begin bad++; $display("FAIL b2b_full got=%b want=1", io.isFull); end
  endtask

  task automatic test_commit();
    do_reset();
    alloc(5'd5, 1'b0, 1'b0, 32'd0);
    rs_put(4'd1, 32'h1234);
    tick();
    clear_cdb();
    total++; if (io.commit_en !== 1'b0) begin bad++; $display("FAIL cm_early got=%b want=0", io.commit_en); end
    tick();
    total++; if (io.commit_en !== 1'b1 || io.commit_rd !== 5'd5 || io.commit_val !== 32'h1234 || io.commit_lab !== 4'd1)
      begin bad++; $display("FAIL cm_normal got=%b/%0d/%h/%0d want=1/5/1234/1", io.commit_en, io.commit_rd, io.commit_val, io.commit_lab); end
    tick();
    total++; if (io.commit_en !== 1'b0) begin bad++; $display("FAIL cm_pulse got=%b want=0", io.commit_en); end
    alloc(5'd6, 1'b0, 1'b0, 32'd0);
    alloc(5'd7, 1'b0, 1'b0, 32'd0);
    alloc(5'd8, 1'b0, 1'b0, 32'd0);
    rs_put(4'd2, 32'hAAAA);
    lsb_put(4'd2, 32'hBBBB);
    tick();
    rs_put(4'd4, 32'h4444);
    lsb_put(4'd3, 32'h3333);
    tick();
    clear_cdb();
    total++; if (io.commit_val !== 32'hAAAA || io.commit_lab !== 4'd2) begin bad++; $display("FAIL cm_rs_wins got=%h/%0d want=aaaa/2", io.commit_val, io.commit_lab); end
    tick();
    total++; if (io.commit_val !== 32'h3333 || io.commit_rd !== 5'd7) begin bad++; $display("FAIL cm_lsb_lane got=%h/%0d want=3333/7", io.commit_val, io.commit_rd); end
    tick();
    total++; if (io.commit_val !== 32'h4444 || io.commit_rd !== 5'd8) begin bad++; $display("FAIL cm_rs_lane got=%h/%0d want=4444/8", io.commit_val, io.commit_rd); end
    alloc(5'd0, 1'b0, 1'b1, 32'd0);
    alloc(5'd0, 1'b0, 1'b0, 32'd0);
    lsb_put(4'd5, 32'd0);
    rs_put(4'd6, 32'h66);
    tick();
    clear_cdb();
    tick();
    total++; if (io.store_commit !== 1'b1 || io.commit_en !== 1'b0 || io.commit_lab !== 4'd5)
      begin bad++; $display("FAIL cm_store got=%b/%b/%0d want=1/0/5", io.store_commit, io.commit_en, io.commit_lab); end
    tick();
    total++; if (io.commit_en !== 1'b1 || io.commit_rd !== 5'd0 || io.commit_val !== 32'h66 || io.store_commit !== 1'b0)
      begin bad++; $display("FAIL cm_rd0 got=%b/%0d/%h/%b want=1/0/66/0", io.commit_en, io.commit_rd, io.commit_val, io.store_commit); end
    rs_put(4'd8, 32'h88);
    tick();
    clear_cdb();
    io.query1_lab = 4'd8;
    #1;
    total++; if (io.ready1 !== 1'b0) begin bad++; $display("FAIL cm_nonbusy got=%b want=0", io.ready1); end
    io.query1_lab = '0;
  endtask

  task automatic test_flush();
    do_reset();
    alloc(5'd1, 1'b0, 1'b0, 32'd0);
    alloc(5'd0, 1'b1, 1'b0, 32'h100);
    alloc(5'd2, 1'b0, 1'b0, 32'd0);
    rs_put(4'd1, 32'd1);
    lsb_put(4'd2, 32'h200);
    tick();
    clear_cdb();
    tick();
    total++; if (io.commit_en !== 1'b1 || io.commit_lab !== 4'd1) begin bad++; $display("FAIL fl_pre got=%b/%0d want=1/1", io.commit_en, io.commit_lab); end
    io.dec2rob_en = 1'b1;
    io.dec_rd     = 5'd7;
    tick();
    total++; if (io.flush !== 1'b1 || io.rob2if_newPC !== 32'h200) begin bad++; $display("FAIL fl_pulse got=%b/%h want=1/200", io.flush, io.rob2if_newPC); end
    total++; if (io.newTag !== 4'd1 || io.isFull !== 1'b0 || io.commit_en !== 1'b0) begin bad++; $display("FAIL fl_clear got=%0d/%b/%b want=1/0/0", io.newTag, io.isFull, io.commit_en); end
    tick();
    io.dec2rob_en = 1'b0;
    total++; if (io.flush !== 1'b0 || io.newTag !== 4'd1) begin bad++; $display("FAIL fl_drop got=%b/%0d want=0/1", io.flush, io.newTag); end
    alloc(5'd0, 1'b1, 1'b0, 32'h40);
    rs_put(4'd1, 32'h40);
    tick();
    clear_cdb();
    tick();
    total++; if ({io.flush, io.commit_en, io.store_commit} !== 3'b000) begin bad++; $display("FAIL fl_correct got=%b want=000", {io.flush, io.commit_en, io.store_commit}); end
    io.query1_lab = 4'd1;
    #1;
    total++; if (io.ready1 !== 1'b0) begin bad++; $display("FAIL fl_retired got=%b want=0", io.ready1); end
    io.query1_lab = '0;
  endtask

  task automatic test_query();
    logic        exp_r;
    logic [31:0] exp_v;
    do_reset();
    for (int k = 0; k < 3; k++) alloc(5'(k + 1), 1'b0, 1'b0, 32'd0);
    exp_r = BYP;
    exp_v = BYP ? 32'd7 : 32'd0;
    io.query1_lab = 4'd3;
    io.query2_lab = 4'd0;
    rs_put(4'd3, 32'd7);
    #1;
    total++; if (io.ready1 !== exp_r || io.res1 !== exp_v) begin bad++; $display("FAIL q_sameclk got=%b/%0d want=%b/%0d", io.ready1, io.res1, exp_r, exp_v); end
    total++; if (io.ready2 !== 1'b1 || io.res2 !== 32'd0) begin bad++; $display("FAIL q_lab0 got=%b/%0d want=1/0", io.ready2, io.res2); end
    tick();
    clear_cdb();
    io.query2_lab = 4'd2;
    #1;
    total++; if (io.ready1 !== 1'b1 || io.res1 !== 32'd7) begin bad++; $display("FAIL q_stored got=%b/%0d want=1/7", io.ready1, io.res1); end
    total++; if (io.ready2 !== 1'b0) begin bad++; $display("FAIL q_notready got=%b want=0", io.ready2); end
    io.query1_lab = '0;
    io.query2_lab = '0;
  endtask

  task automatic test_stall();
    do_reset();
    alloc(5'd3, 1'b0, 1'b0, 32'd0);
    io.rdy_in     = 1'b0;
    io.dec2rob_en = 1'b1;
    rs_put(4'd1, 32'd5);
    tick();
    clear_cdb();
    io.dec2rob_en = 1'b0;
    io.query1_lab = 4'd1;
    #1;
    total++; if (io.ready1 !== 1'b0 || io.newTag !== 4'd2) begin bad++; $display("FAIL st_frozen got=%b/%0d want=0/2", io.ready1, io.newTag); end
    io.rdy_in = 1'b1;
    rs_put(4'd1, 32'd5);
    tick();
    clear_cdb();
    io.rdy_in = 1'b0;
    tick();
    total++; if (io.commit_en !== 1'b0) begin bad++; $display("FAIL st_nocommit got=%b want=0", io.commit_en); end
    io.rdy_in = 1'b1;
    tick();
    total++; if (io.commit_en !== 1'b1 || io.commit_val !== 32'd5 || io.commit_rd !== 5'd3) begin bad++; $display("FAIL st_resume got=%b/%0d/%0d want=1/5/3", io.commit_en, io.commit_val, io.commit_rd); end
    io.query1_lab = '0;
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_full();
    test_back_to_back();
    test_commit();
    test_flush();
    test_query();
    test_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
